// File: rtl/module_disp_scheduler.sv
// module_disp_scheduler: binary-to-BCD conversion via sequential double-dabble,
// atomic display latch and free-running 4-digit 7-segment scan.
module module_disp_scheduler #(
  parameter int FREQ_HZ    = 27_000_000,
  parameter int REFRESH_HZ = 1_000,
  parameter int INVERT_AN  = 1,
  parameter int INVERT_SEG = 0,
  parameter int BLANK_LZ   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [13:0] in_data,
  output logic        in_ready,
  output logic        busy,
  output logic [3:0]  a,
  output logic [6:0]  seg
);
  localparam int MAX_COUNT = (FREQ_HZ / REFRESH_HZ) < 1 ? 1 : FREQ_HZ / REFRESH_HZ;
  localparam int CW = MAX_COUNT > 1 ? $clog2(MAX_COUNT) : 1;
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, LATCH = 2'd2;
  logic [1:0]    state_q, state_d, idx_q, idx_d;
  logic [13:0]   bin_q, bin_d;
  logic [15:0]   bcd_q, bcd_d, disp_q, disp_d, adj;
  logic [3:0]    it_q, it_d, onehot, nib;
  logic [CW-1:0] ref_q, ref_d;
  logic          tick, blank;
  logic [6:0]    glyph;
  always_comb begin
    for (int i = 0; i < 4; i++)
      adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
  end
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    it_d    = it_q;
    disp_d  = disp_q;
    case (state_q)
      IDLE: if (in_valid) begin
        bin_d   = in_data > 14'd9999 ? 14'd9999 : in_data;
        bcd_d   = '0;
        it_d    = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        {bcd_d, bin_d} = {adj[14:0], bin_q, 1'b0};
        it_d           = it_q + 4'd1;
        state_d        = it_q == 4'd13 ? LATCH : SHIFT;
      end
      LATCH: begin
        disp_d  = bcd_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign tick  = ref_q == CW'(MAX_COUNT - 1);
  assign ref_d = tick ? '0 : ref_q + 1'b1;
  assign idx_d = tick ? idx_q + 2'd1 : idx_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      it_q    <= '0;
      disp_q  <= '0;
      idx_q   <= '0;
      ref_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      it_q    <= it_d;
      disp_q  <= disp_d;
      idx_q   <= idx_d;
      ref_q   <= ref_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign busy     = ~in_ready;
  assign onehot   = 4'b0001 << idx_q;
  assign a        = INVERT_AN != 0 ? ~onehot : onehot;
  assign nib      = disp_q[{idx_q, 2'b00} +: 4];
  // a digit is a leading zero when it and every higher digit are zero
  assign blank    = BLANK_LZ != 0 && idx_q != 2'd0 && (disp_q >> {idx_q, 2'b00}) == 16'd0;
  always_comb begin
    case (nib)
      4'd0:    glyph = 7'b0111111;
      4'd1:    glyph = 7'b0000110;
      4'd2:    glyph = 7'b1011011;
      4'd3:    glyph = 7'b1001111;
      4'd4:    glyph = 7'b1100110;
      4'd5:    glyph = 7'b1101101;
      4'd6:    glyph = 7'b1111101;
      4'd7:    glyph = 7'b0000111;
      4'd8:    glyph = 7'b1111111;
      4'd9:    glyph = 7'b1101111;
      default: glyph = 7'b0000000;
    endcase
  end
  assign seg = (blank ? 7'b0000000 : glyph) ^ {7{INVERT_SEG != 0}};
endmodule
